// File: rtl/blink_checker.sv
// Blink pattern checker.
// Observes an asynchronous 4-bit bus. On every prescaler tick the checker
// captures the synchronized value and confirms that the bus shows INIT first
// and then inverts on every later tick. A single wrong capture sets a sticky
// error; only clr or rstn clears it.
module blink_checker #(
  parameter int         N    = 22,
  parameter logic [3:0] INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic [3:0] data,
  output logic [3:0] sample,
  output logic       valid,
  output logic [7:0] changes,
  output logic       locked,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t         state;
  logic [3:0]     meta;
  logic [3:0]     ds;
  logic [N-1:0]   prescaler;
  logic           tick;

  // Two-flop synchronizer. Only ds is used downstream; meta may go metastable.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its input before any flop updates.
    if (!rstn) begin
      meta <= '0;
      ds   <= '0;
    end else begin
      meta <= data;
      ds   <= meta;
    end
  end

  // Free-running prescaler. clr leaves it alone, so the tick phase is kept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // The tick is active in the last cycle of each prescaler period.
  assign tick = &prescaler;

  // Checker FSM. It captures the bus on each tick, compares the new value
  // against the previous sample, and registers all outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sample  <= '0;
      valid   <= 1'b0;
      changes <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      // NOTE: clr has priority over a tick in the same cycle. Nothing is
      // captured on that edge, so the next tick is the first capture.
      state   <= IDLE;
      sample  <= '0;
      valid   <= 1'b0;
      changes <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= tick;
      if (tick) begin
        sample <= ds;
        case (state)
          IDLE: begin
            if (ds == INIT) begin
              state <= SYNC;
            end else begin
              state <= FAIL;
              err   <= 1'b1;
            end
          end
          SYNC, CHECK: begin
            // Compare against the sample held before this edge.
            if (ds == ~sample) begin
              state  <= CHECK;
              locked <= 1'b1;
              if (changes != 8'hFF) begin
                changes <= changes + 8'd1;
              end
            end else begin
              state  <= FAIL;
              locked <= 1'b0;
              err    <= 1'b1;
            end
          end
          FAIL: begin
            // Captures continue. No compare is made and changes stays frozen.
          end
          default: begin
            state  <= FAIL;
            locked <= 1'b0;
            err    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_checker.sv
// Testbench for blink_checker with N=1 (one tick every two cycles).
// A reference model runs on each clock edge. On every capture edge it pushes
// the expected outputs into a queue. A monitor on the opposite clock edge
// pops an entry and compares it whenever valid is high.
module tb_blink_checker;

  localparam int         N      = 1;
  localparam logic [3:0] INIT   = 4'b0000;
  localparam int         PERIOD = 1 << N;

  logic       clk;
  logic       rstn;
  logic       clr;
  logic [3:0] data;
  logic [3:0] sample;
  logic       valid;
  logic [7:0] changes;
  logic       locked;
  logic       err;

  blink_checker #(.N(N), .INIT(INIT)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .data    (data),
    .sample  (sample),
    .valid   (valid),
    .changes (changes),
    .locked  (locked),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sample;
    logic [7:0] changes;
    logic       locked;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. The bus reaches the checker two edges late. A capture
  // happens on every PERIOD-th edge after reset release.
  int         c;
  logic [3:0] h1, h2, cap;
  int         n_caps;
  bit         m_failed;
  logic [3:0] m_sample;
  int         m_changes;
  bit         ok;

  function automatic void model_clear();
    n_caps    = 0;
    m_failed  = 0;
    m_sample  = '0;
    m_changes = 0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c  = 0;
      h1 = '0;
      h2 = '0;
      model_clear();
      sb_q.delete();
    end else begin
      c++;
      cap = h2;
      h2  = h1;
      h1  = data;
      if (clr) begin
        model_clear();
      end else if (c % PERIOD == 0) begin
        if (!m_failed) begin
          ok = (n_caps == 0) ? (cap == INIT) : (cap == ~m_sample);
          if (!ok) m_failed = 1;
          else if (n_caps > 0 && m_changes < 255) m_changes++;
        end
        m_sample = cap;
        n_caps++;
        sb_q.push_back('{sample: m_sample, changes: m_changes[7:0],
                         locked: (!m_failed && n_caps >= 2), err: m_failed});
      end
    end
  end

  // Monitor: compares each valid pulse against the next expected entry.
  always @(negedge clk) begin
    if (rstn && valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", valid, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_sample",  sample,  e.sample);
        check("sb_changes", changes, e.changes);
        check("sb_locked",  locked,  e.locked);
        check("sb_err",     err,     e.err);
      end
    end
  end

  // Returns at the falling edge just before a tick edge.
  task automatic wait_pre_tick();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((c % PERIOD) != PERIOD - 1 && guard < 16);
    if (guard >= 16) check("tick_wait_timeout", guard, 0);
  endtask

  // Inverts the bus once per tick period. The value lands on a tick edge,
  // so each capture sees one full, stable period.
  task automatic toggle(input int k);
    for (int i = 0; i < k; i++) begin
      wait_pre_tick();
      data = ~data;
    end
  endtask

  // Pulses clr on a tick edge, with the bus at v from that edge onward.
  task automatic clr_on_tick(input logic [3:0] v);
    wait_pre_tick();
    clr  = 1'b1;
    data = v;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample"},  sample,  4'h0);
    check({tag, "_valid"},   valid,   1'b0);
    check({tag, "_changes"}, changes, 8'h00);
    check({tag, "_locked"},  locked,  1'b0);
    check({tag, "_err"},     err,     1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rstn = 1'b0;
    clr  = 1'b0;
    data = 4'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;

    // Aligned toggling: 19 captures complete, giving 18 changes.
    toggle(20);
    check("lock_locked",  locked,  1'b1);
    check("lock_err",     err,     1'b0);
    check("lock_changes", changes, 8'd18);

    // A single bad value leads to a sticky error.
    wait_pre_tick();
    data = 4'b0101;
    toggle(25);
    check("bad_err",     err,     1'b1);
    check("bad_locked",  locked,  1'b0);
    check("bad_changes", changes, 8'd20);

    // clr on a tick edge: nothing is captured, state returns to idle, and
    // the next capture of 0000 moves to SYNC.
    clr_on_tick(4'h0);
    check_all_zero("clr");
    @(negedge clk);
    @(negedge clk);
    check("clr_sync_locked", locked, 1'b0);
    check("clr_sync_err",    err,    1'b0);
    check("clr_sync_valid",  valid,  1'b1);

    // Relock until changes reaches 10, then reset asynchronously.
    clr_on_tick(4'h0);
    toggle(12);
    check("pre_rst_changes", changes, 8'd10);
    check("pre_rst_locked",  locked,  1'b1);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 rstn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = i;
        break;
      end
    end
    check("valid_latency", lat, 2);

    // First capture after clear is 0011, which does not match INIT.
    data = 4'b0011;
    repeat (4) @(negedge clk);
    clr_on_tick(4'b0011);
    @(negedge clk);
    @(negedge clk);
    check("init_bad_err",     err,     1'b1);
    check("init_bad_locked",  locked,  1'b0);
    check("init_bad_changes", changes, 8'd0);
    check("init_bad_sample",  sample,  4'b0011);

    // Long stream: changes saturates at 255 and lock holds.
    clr_on_tick(4'h0);
    toggle(300);
    check("sat_changes", changes, 8'hFF);
    check("sat_locked",  locked,  1'b1);
    check("sat_err",     err,     1'b0);

    repeat (2) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
